fp_add_pipe: RTL
================

# fp_add_pipe

Parametrised, three-stage pipelined floating-point adder/subtractor for the team's custom sign/exponent/explicit-fraction format, generalising the 13-bit combinational adder. It adds valid/ready flow control, an add/subtract mode, full guard/round/sticky round-to-nearest-even on the result, and overflow/underflow flags. It sits between operand-producing datapath blocks and downstream accumulators or FIFOs that may apply backpressure.

## Interface
- EXP_W, 4, exponent field width (unsigned, no bias)
- FRAC_W, 8, fraction field width; normalised fraction has MSB = 1 (explicit leading one)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  operand pair valid
- i_ready  out  1  block accepts operands this cycle
- i_sub  in  1  0: a+b, 1: a-b
- i_a, i_b  in  1+EXP_W+FRAC_W  operands {sign, exp, frac}
- o_valid  out  1  result valid
- o_ready  in  1  downstream accepts result
- o_res  out  1+EXP_W+FRAC_W  result {sign, exp, frac}
- o_overflow  out  1  result saturated (qualified by o_valid)
- o_underflow  out  1  nonzero result flushed to zero (qualified by o_valid)

## Operation
- Value = (-1)^s × 0.frac × 2^exp. Zero = frac==0 (any exp, any sign). Non-normalised nonzero inputs are out of spec.
- Effective b sign = b.sign ^ i_sub.
- Stage 1 (align): compare {exp,frac} magnitudes; larger is big, smaller is small (tie: b is big). diff = exp_big − exp_small. Small fraction is extended by 3 low bits (G,R,S) and right-shifted by diff; bits shifted past S are OR'd into S. diff ≥ FRAC_W+3 leaves only sticky.
- Stage 2 (add): same effective signs → add, else big − small, on FRAC_W+4 bits (carry + FRAC_W + GRS). Result sign = big sign.
- Stage 3 (normalise/round):
  - carry set: shift right 1 (shifted-out bit OR'd into S), exp+1.
  - else lz = leading zeros of the FRAC_W+3-bit sum. If sum==0 → result +0 (sign 0), no flags. If lz > exp_big → result +0, o_underflow=1. Else shift left lz, exp − lz.
  - RNE: round up iff G & (R | S | lsb). Round carry-out gives frac = 100…0, exp+1.
  - Exp exceeding 2^EXP_W−1 → saturate to exp all ones, frac all ones, sign kept, o_overflow=1.
- Exact cancellation always gives +0.

## Timing
- Latency 3 cycles from accepted input (i_valid & i_ready) to o_valid, with no stall.
- Throughput: 1 result/cycle.
- Global advance enable: en = !o_valid | o_ready. i_ready = en. All stage registers and valid bits load only when en=1. Bubbles propagate as valid=0.
- While o_valid=1 and o_ready=0: o_res and flags are held stable, the whole pipeline freezes, and i_ready=0.
- Results emerge in input order. None are dropped or duplicated.
- Reset (asynchronous, any time, including mid-stall): all valid bits 0, o_res=0, flags 0, in-flight operations discarded. i_ready=1 after reset.
- i_ready is combinational from o_valid/o_ready. No other combinational input→output path exists.

## Test plan
Defaults EXP_W=4, FRAC_W=8, hex 13-bit words.
- a=0x180, b=0x180, i_sub=0 → o_res=0x280 exactly 3 cycles after acceptance, flags 0.
- a=0x180, b=0x180, i_sub=1 → o_res=0x000, flags 0.
- RNE ties:
  - a=0x480, b=0x088 → 0x488 (tie, even kept).
  - a=0x480, b=0x098 → 0x48A (tie, rounded up to even).
- a=0xFFF, b=0xFFF, add → 0xFFF with o_overflow=1. Then a=0x181, b=0x180, i_sub=1 → 0x000 with o_underflow=1.
- Hold o_ready=0 while offering 5 back-to-back pairs. Exactly 3 are accepted, i_ready then stays 0. o_res is stable while stalled. On release, all accepted results appear in order, one per cycle.
- Assert rst_n=0 during the stall above → o_valid=0 immediately, o_res=0. After release, a fresh pair yields a correct result in 3 cycles with no stale outputs.

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe
//   Three-stage pipelined floating-point adder/subtractor for the
//   sign/exponent/explicit-fraction format:
//     value = (-1)^sign * 0.frac * 2^exp, exponent unsigned (no bias),
//     normalised fraction has its MSB set, frac == 0 means zero.
//   Stages: align (p1), add/subtract (p2), normalise + round-to-nearest-even
//   (output register). A single advance enable freezes the whole pipe while
//   the output is valid and not accepted downstream.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   i_valid / i_ready    operand handshake; i_ready = !o_valid | o_ready
//   i_sub                0: a + b, 1: a - b
//   i_a, i_b             operands {sign, exp[EXP_W-1:0], frac[FRAC_W-1:0]}
//   o_valid / o_ready    result handshake
//   o_res                result {sign, exp, frac}
//   o_overflow           result saturated to max magnitude (with o_valid)
//   o_underflow          nonzero result flushed to +0 (with o_valid)
module fp_add_pipe #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic                  i_sub,
    input  logic [EXP_W+FRAC_W:0] i_a,
    input  logic [EXP_W+FRAC_W:0] i_b,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [EXP_W+FRAC_W:0] o_res,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int MW  = EXP_W + FRAC_W;      // {exp, frac} magnitude key
    localparam int XW  = FRAC_W + 3;          // fraction + guard/round/sticky
    localparam int SW  = FRAC_W + 4;          // extended fraction + carry
    localparam int EW  = EXP_W + 2;           // exponent with overflow headroom
    localparam int LZW = $clog2(XW + 1);
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    // Right shift that folds every bit pushed past the sticky position into
    // the sticky bit. Shifts of XW or more leave only the sticky bit.
    function automatic logic [XW-1:0] align_shift(input logic [XW-1:0] v,
                                                   input logic [EXP_W-1:0] sh);
        logic [XW-1:0] kept;
        logic [XW-1:0] lost;
        kept = v >> sh;
        lost = v & ~({XW{1'b1}} << sh);
        return {kept[XW-1:1], kept[0] | (|lost)};
    endfunction

    // Leading-zero count of the extended fraction (XW when all zero).
    function automatic logic [LZW-1:0] lzc(input logic [XW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(XW);
        for (int i = 0; i < XW; i++) begin
            if (v[i]) n = LZW'(XW - 1 - i);
        end
        return n;
    endfunction

    // Round-to-nearest-even on {frac, G, R, S}; MSB of the result is the
    // carry out of the rounding increment.
    function automatic logic [FRAC_W:0] round_rne(input logic [XW-1:0] v);
        logic up;
        up = v[2] & (v[1] | v[0] | v[3]);
        return {1'b0, v[XW-1:3]} + {{FRAC_W{1'b0}}, up};
    endfunction

    // Largest representable magnitude with the given sign.
    function automatic logic [W-1:0] sat_word(input logic s);
        return {s, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
    endfunction

    logic en;
    assign en      = !o_valid | o_ready;
    assign i_ready = en;

    // ---------------- stage 1: compare and align ----------------
    logic              sa, sb, a_big;
    logic [MW-1:0]     mag_a, mag_b, mag_big, mag_small;
    logic [EXP_W-1:0]  diff;
    logic              sign_big;

    always_comb begin
        sa = i_a[W-1];
        sb = i_b[W-1] ^ i_sub;
        // A zero operand compares as the smallest magnitude regardless of
        // its exponent field, so it never dictates the result exponent.
        mag_a = (i_a[FRAC_W-1:0] == '0) ? '0 : i_a[MW-1:0];
        mag_b = (i_b[FRAC_W-1:0] == '0) ? '0 : i_b[MW-1:0];
        a_big = mag_a > mag_b;
        mag_big   = a_big ? mag_a : mag_b;
        mag_small = a_big ? mag_b : mag_a;
        sign_big  = a_big ? sa : sb;
        diff = mag_big[MW-1:FRAC_W] - mag_small[MW-1:FRAC_W];
    end

    logic              vld_p1;
    logic              sign_p1;
    logic              sub_p1;
    logic [EXP_W-1:0]  exp_p1;
    logic [XW-1:0]     big_p1;
    logic [XW-1:0]     small_p1;

    always_ff @(posedge clk) begin
        if (en) begin
            sign_p1  <= sign_big;
            sub_p1   <= sa ^ sb;
            exp_p1   <= mag_big[MW-1:FRAC_W];
            big_p1   <= {mag_big[FRAC_W-1:0], 3'b000};
            small_p1 <= align_shift({mag_small[FRAC_W-1:0], 3'b000}, diff);
        end
    end

    // ---------------- stage 2: add / subtract magnitudes ----------------
    logic              vld_p2;
    logic              sign_p2;
    logic [EXP_W-1:0]  exp_p2;
    logic [SW-1:0]     sum_p2;

    // big >= small always holds, so the difference never goes negative.
    always_ff @(posedge clk) begin
        if (en) begin
            sign_p2 <= sign_p1;
            exp_p2  <= exp_p1;
            sum_p2  <= sub_p1 ? ({1'b0, big_p1} - {1'b0, small_p1})
                              : ({1'b0, big_p1} + {1'b0, small_p1});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p1 <= i_valid;
            vld_p2 <= vld_p1;
        end
    end

    // ---------------- stage 3: normalise, round, saturate ----------------
    logic [LZW-1:0]    lz;
    logic [XW-1:0]     norm;
    logic [EW-1:0]     exp_n, exp_r;
    logic [FRAC_W:0]   rnd;
    logic [FRAC_W-1:0] frac_r;
    logic              zero_r, ovf, unf;
    logic [W-1:0]      res;

    always_comb begin
        lz     = lzc(sum_p2[XW-1:0]);
        norm   = '0;
        exp_n  = '0;
        zero_r = 1'b0;
        unf    = 1'b0;
        ovf    = 1'b0;
        res    = '0;
        if (sum_p2[SW-1]) begin
            // Carry out of the add: the bit dropped off the bottom joins sticky.
            norm  = {sum_p2[SW-1:2], sum_p2[1] | sum_p2[0]};
            exp_n = EW'(exp_p2) + EW'(1);
        end else if (sum_p2[XW-1:0] == '0) begin
            zero_r = 1'b1;
        end else if (EW'(lz) > EW'(exp_p2)) begin
            // Normalising would need a negative exponent.
            zero_r = 1'b1;
            unf    = 1'b1;
        end else begin
            norm  = sum_p2[XW-1:0] << lz;
            exp_n = EW'(exp_p2) - EW'(lz);
        end

        rnd    = round_rne(norm);
        frac_r = rnd[FRAC_W-1:0];
        exp_r  = exp_n;
        if (rnd[FRAC_W]) begin
            frac_r = {1'b1, {(FRAC_W-1){1'b0}}};
            exp_r  = exp_n + EW'(1);
        end

        if (zero_r) begin
            res = '0;
        end else if (exp_r > EXP_MAX) begin
            res = sat_word(sign_p2);
            ovf = 1'b1;
        end else begin
            res = {sign_p2, exp_r[EXP_W-1:0], frac_r};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid     <= 1'b0;
            o_res       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (en) begin
            o_valid     <= vld_p2;
            o_res       <= res;
            o_overflow  <= vld_p2 & ovf;
            o_underflow <= vld_p2 & unf;
        end
    end

endmodule
